mem_load_controller: RTL
========================

MEM_LOAD_CONTROLLER -- requirements
Module: mem_load_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, data-register address width (16 locations).
REQ-002 SHALL have parameter DATA_W, default 8, byte width of stream and register data.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, stream byte present.
REQ-006 SHALL have port in_data, input, DATA_W, stream byte.
REQ-007 SHALL have port in_ready, output, 1, controller accepts byte; transfer when in_valid && in_ready at a rising clk edge.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current transfer.
REQ-009 SHALL have port load, output, 1, write strobe to the data/instruction register.
REQ-010 SHALL have port is_instruction, output, 1, target select registered from the header.
REQ-011 SHALL have port load_address, output, ADDR_W, write address.
REQ-012 SHALL have port cpu_input, output, DATA_W, write data.
REQ-013 SHALL have port cpu_halt, output, 1, holds the CPU while a transfer is in progress.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1, error flag of the last transfer.

Function
REQ-016 SHALL implement FSM states IDLE, HDR1, DATA, CHK, FIN.
REQ-017 IDLE: accepted byte is header 0; bit0 -> is_instruction register; bits[7:1] nonzero -> header error; next state HDR1, err cleared.
REQ-018 HDR1: accepted byte bits[7:4] -> base address, bits[3:0] -> count-1 (1..16 payload bytes); next DATA.
REQ-019 DATA: each accepted byte SHALL produce load=1 for exactly one cycle on the cycle after acceptance, with cpu_input = that byte and load_address = base + index.
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_W; base 0xE, count 4 writes 0xE, 0xF, 0x0, 0x1.
REQ-021 After the last payload byte is accepted, next state SHALL be CHK if LOAD_CHECKSUM_EN is defined, else FIN.
REQ-022 FIN SHALL last exactly one cycle, with done=1 and in_ready=0, then return to IDLE.
REQ-023 in_ready SHALL be 1 in IDLE, HDR1, DATA, CHK when abort=0, and 0 otherwise; one byte at most per cycle, back-to-back accepted.
REQ-024 cpu_halt SHALL be 1 in every state except IDLE, and also during the trailing load cycle of the final byte.
REQ-025 Header error: no load pulses SHALL be issued for that transfer; payload bytes are still consumed, and err=1 is set with done.
REQ-026 abort=1 in any non-IDLE state SHALL discard the current byte, suppress further loads (a load already registered still completes), and go to FIN with err=1.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 err SHALL hold until the next header-0 acceptance.

Reset
REQ-029 rst SHALL force state IDLE, load=0, is_instruction=0, load_address=0, cpu_input=0, cpu_halt=0, done=0, err=0 immediately, independent of clk.
REQ-030 rst mid-transfer SHALL abandon the transfer; no load is issued after reset deasserts until a new header is received.

Configuration
REQ-031 Macro LOAD_CHECKSUM_EN defined: after the payload, one checksum byte SHALL be accepted in CHK; mismatch with the 8-bit modulo-256 sum of the payload sets err=1 at FIN. Loads are not retracted.
REQ-032 Macro LOAD_CHECKSUM_EN undefined: the CHK state and the sum register SHALL be absent, and DATA goes directly to FIN.

Structure
REQ-033 A shared package SHALL hold the state enum, header field positions, and the ADDR_W/DATA_W defaults.
REQ-034 SHALL be a single module; no sub-module is needed. It drives an existing data register instance directly via load, is_instruction, load_address, and cpu_input.

Verification
REQ-035 Headers 0x00, 0x23 plus bytes 0x11, 0x22, 0x33, 0x44 -> loads to addresses 2..5 with data 0x11..0x44, is_instruction=0, then done pulse and err=0.
REQ-036 Headers 0x01, 0xE3 plus four bytes -> is_instruction=1, addresses 0xE, 0xF, 0x0, 0x1 (wrap).
REQ-037 Header 0x02 -> no load for the whole transfer, err=1 at done.
REQ-038 abort asserted after 2 of 4 payload bytes -> exactly 2 loads, done and err=1, then IDLE with in_ready=1.
REQ-039 LOAD_CHECKSUM_EN, payload 0x80, 0x81, checksum 0x01 -> err=0; checksum 0x02 -> err=1.
REQ-040 rst pulse mid-DATA -> all outputs 0 in the same cycle, and the next transfer starts cleanly from header 0.

Source files
------------

// File: rtl/mem_load_controller_pkg.sv
// mem_load_controller_pkg: shared widths, FSM state codes and header field positions.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W - default register address and data widths
//   ST_*                    - FSM state codes (IDLE, HDR1, DATA, CHK, FIN)
//   HDR*_                   - bit positions of the header-0 and header-1 fields
package mem_load_controller_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR1 = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // header 0: bit0 selects the instruction register, all higher bits must be zero
    localparam int HDR0_INSTR_BIT = 0;
    // header 1: [7:4] base address, [3:0] payload count minus one
    localparam int HDR1_BASE_LSB = 4;
    localparam int HDR1_CNT_LSB  = 0;
    localparam int HDR_FIELD_W   = 4;

endpackage

// File: rtl/mem_load_controller_if.sv
// mem_load_controller_if: byte-stream input and register-write bus of the load controller.
// Signals:
//   in_valid/in_data/in_ready - byte stream handshake (transfer on valid && ready)
//   abort                     - synchronous cancel of the current transfer
//   load/is_instruction/load_address/cpu_input - register write port
//   cpu_halt/done/err         - CPU hold, completion pulse, error flag
// Modports: master (stream source / register consumer), slave (controller).
interface mem_load_controller_if
    import mem_load_controller_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              abort;
    logic              load;
    logic              is_instruction;
    logic [ADDR_W-1:0] load_address;
    logic [DATA_W-1:0] cpu_input;
    logic              cpu_halt;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, load, is_instruction, load_address, cpu_input, cpu_halt, done, err
    );

    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, load, is_instruction, load_address, cpu_input, cpu_halt, done, err
    );
endinterface

// File: rtl/mem_load_controller.sv
// mem_load_controller: decodes a header + payload byte stream into register write strobes.
// Ports:
//   clk - clock, all state changes on its rising edge
//   rst - asynchronous active-high reset
//   bus - mem_load_controller_if.slave (stream in, register write out, halt/done/err)
// Optional feature: define LOAD_CHECKSUM_EN to accept and verify a modulo-256 checksum
// byte after the payload; undefined, DATA goes straight to FIN and no sum is kept.
module mem_load_controller
    import mem_load_controller_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic                  clk,
    input logic                  rst,
    mem_load_controller_if.slave bus
);

    logic [2:0]             state_q, state_d;
    logic                   is_instr_q, is_instr_d;
    logic                   hdr_err_q, hdr_err_d;
    logic                   err_q, err_d;
    logic                   load_q, load_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [HDR_FIELD_W-1:0] cnt_q, cnt_d;
    logic [HDR_FIELD_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]      data_q, data_d;
`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0]      sum_q, sum_d;
`endif
    logic                   mid;
    logic                   accept;

    // abort only acts while a transfer is being received, never in IDLE or FIN
    assign mid    = state_q != ST_IDLE && state_q != ST_FIN;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready       = state_q != ST_FIN && !bus.abort;
    assign bus.load           = load_q;
    assign bus.is_instruction = is_instr_q;
    assign bus.load_address   = addr_q;
    assign bus.cpu_input      = data_q;
    // the final byte's load lands in the cycle after acceptance, so load_q extends the hold
    assign bus.cpu_halt       = state_q != ST_IDLE || load_q;
    assign bus.done           = state_q == ST_FIN;
    assign bus.err            = err_q;

    always_comb begin
        state_d    = state_q;
        is_instr_d = is_instr_q;
        hdr_err_d  = hdr_err_q;
        err_d      = err_q;
        load_d     = 1'b0;
        base_d     = base_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
`ifdef LOAD_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (mid && bus.abort) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    is_instr_d = bus.in_data[HDR0_INSTR_BIT];
                    hdr_err_d  = |bus.in_data[DATA_W-1:1];
                    err_d      = 1'b0;
                    state_d    = ST_HDR1;
                end
                ST_HDR1: if (accept) begin
                    base_d  = ADDR_W'(bus.in_data[HDR1_BASE_LSB +: HDR_FIELD_W]);
                    cnt_d   = bus.in_data[HDR1_CNT_LSB +: HDR_FIELD_W];
                    idx_d   = '0;
`ifdef LOAD_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = ST_DATA;
                end
                ST_DATA: if (accept) begin
                    // a bad header still consumes the payload but never writes
                    load_d = !hdr_err_q;
                    if (!hdr_err_q) begin
                        addr_d = base_q + ADDR_W'(idx_q);
                        data_d = bus.in_data;
                    end
                    idx_d = idx_q + 1'b1;
`ifdef LOAD_CHECKSUM_EN
                    sum_d = sum_q + bus.in_data;
                    if (idx_q == cnt_q) state_d = ST_CHK;
`else
                    if (idx_q == cnt_q) begin
                        state_d = ST_FIN;
                        err_d   = hdr_err_q;
                    end
`endif
                end
`ifdef LOAD_CHECKSUM_EN
                ST_CHK: if (accept) begin
                    // loads already issued are not retracted on a mismatch
                    err_d   = hdr_err_q || bus.in_data != sum_q;
                    state_d = ST_FIN;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_instr_q <= 1'b0;
            hdr_err_q  <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
            base_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
`ifdef LOAD_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            is_instr_q <= is_instr_d;
            hdr_err_q  <= hdr_err_d;
            err_q      <= err_d;
            load_q     <= load_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
`ifdef LOAD_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule
